wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: REG_FILE_BITS, default 5, register index width; REG_FILE_SIZE, default 32, register count; REG_SIZE, default 32, data width.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 alu_valid  in  1  ALU write-back request.
REQ-005 alu_ready  out  1  ALU request accepted this cycle.
REQ-006 alu_rd / alu_data  in  REG_FILE_BITS / REG_SIZE  ALU destination index and value.
REQ-007 mem_valid  in  1  load-unit write-back request.
REQ-008 mem_ready  out  1  load request accepted this cycle.
REQ-009 mem_rd / mem_data  in  REG_FILE_BITS / REG_SIZE  load destination index and value.
REQ-010 iss_valid / iss_rd  in  1 / REG_FILE_BITS  issue stage marks iss_rd pending.
REQ-011 rs1 / rs2  in  REG_FILE_BITS  decode-stage source indices.
REQ-012 haz1 / haz2  out  1  source register has a pending write.
REQ-013 wb_we / wb_num / wb_value  out  1 / REG_FILE_BITS / REG_SIZE  register-file write port (registered).

Function
REQ-014 Transfer SHALL occur when valid && ready; ready SHALL be combinational from valids and the priority bit, with no dependency on ready from the requester side.
REQ-015 At most one of alu_ready, mem_ready SHALL be high per cycle; a lone valid requester SHALL be granted immediately.
REQ-016 On contention the grant SHALL go to the requester indicated by a priority bit (reset value: ALU); after any grant the priority bit SHALL point to the other requester (round-robin).
REQ-017 A granted request SHALL appear on wb_we/wb_num/wb_value exactly one posedge later; wb_we SHALL be low in cycles with no grant.
REQ-018 A granted request with rd == 0 SHALL be accepted (ready high) but SHALL produce wb_we = 0.
REQ-019 Scoreboard: busy[REG_FILE_SIZE] bits; iss_valid with iss_rd != 0 SHALL set busy[iss_rd] at the next posedge.
REQ-020 A posedge with wb_we high SHALL clear busy[wb_num]; if iss_valid targets the same index in that cycle, set SHALL win.
REQ-021 haz1 = busy[rs1], haz2 = busy[rs2], combinational; index 0 SHALL always return 0.
REQ-022 Un-granted requests SHALL be held unchanged by the requester; the block SHALL NOT buffer them.

Reset
REQ-023 On rst_n low, asynchronously: wb_we = 0, wb_num = 0, wb_value = 0, all busy bits = 0, priority = ALU; alu_ready/mem_ready SHALL be 0 while rst_n is low.
REQ-024 A reset asserted mid-operation SHALL discard the in-flight write (wb_we forced 0); no write SHALL reach the register file after reset release until a new grant.

Configuration
REQ-025 Macro WB_ARBITER_FWD_EN, when defined, SHALL add outputs fwd1_valid/fwd1_data and fwd2_valid/fwd2_data: fwdN_valid = wb_we && wb_num == rsN && rsN != 0, fwdN_data = wb_value, and hazN SHALL be masked to 0 when fwdN_valid is high.
REQ-026 Without WB_ARBITER_FWD_EN, those ports SHALL be absent and hazN SHALL follow busy only.

Structure
REQ-027 A shared package SHALL hold REG_FILE_BITS/REG_SIZE defaults, the wb_req_t typedef (valid, rd, data) and the requester-id enum (REQ_ALU, REQ_MEM).
REQ-028 Round-robin grant logic SHALL be one sub-module, rr_arb2 (two requests, two grants, priority register).

Verification
REQ-029 alu_valid only, alu_rd = 5, alu_data = 0xDEADBEEF -> alu_ready same cycle; next cycle wb_we = 1, wb_num = 5, wb_value = 0xDEADBEEF.
REQ-030 Both valid for 4 cycles after reset (alu_rd = 1, mem_rd = 2) -> grants ALU, MEM, ALU, MEM; wb_num 1, 2, 1, 2 one cycle delayed.
REQ-031 mem_valid, mem_rd = 0, mem_data = 0x1234 -> mem_ready = 1, following cycle wb_we = 0.
REQ-032 iss_valid, iss_rd = 7; rs1 = 7 -> haz1 = 1 from next cycle; ALU write to x7 -> haz1 = 0 the cycle after wb_we; simultaneous iss to x7 with wb to x7 -> haz1 stays 1.
REQ-033 Grant to ALU x3, rst_n pulsed low before the next posedge -> wb_we = 0, busy all 0, priority = ALU.
REQ-034 With WB_ARBITER_FWD_EN: wb_we = 1, wb_num = 9, wb_value = 0x55, rs2 = 9, busy[9] = 1 -> fwd2_valid = 1, fwd2_data = 0x55, haz2 = 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the write-back arbiter: requester ids,
// the write-back request record and default register-file geometry.
package wb_arbiter_pkg;

  localparam int REG_FILE_BITS_DEF = 5;
  localparam int REG_FILE_SIZE_DEF = 32;
  localparam int REG_SIZE_DEF      = 32;

  // Requester id doubles as the bit position in the request/grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                         valid;
    logic [REG_FILE_BITS_DEF-1:0] rd;
    logic [REG_SIZE_DEF-1:0]      data;
  } wb_req_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage : wb_arbiter_pkg

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone request wins immediately, ties go
// to the priority register, which then points at the loser of the last grant.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    // Grants are forced off while reset is held so no requester sees ready.
    if (rst_n) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      prio_d = other_req(REQ_ALU);
    end else if (gnt_o[1]) begin
      prio_d = other_req(REQ_MEM);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : rr_arb2

// File: rtl/wb_arbiter.sv
// Write-back arbiter between ALU and load unit with a pending-write scoreboard.
// Optional operand forwarding from the write port is enabled by WB_ARBITER_FWD_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REG_FILE_BITS = REG_FILE_BITS_DEF,
  parameter int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
  parameter int REG_SIZE      = REG_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_FILE_BITS-1:0] alu_rd,
  input  logic [REG_SIZE-1:0]      alu_data,

  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_FILE_BITS-1:0] mem_rd,
  input  logic [REG_SIZE-1:0]      mem_data,

  input  logic                     iss_valid,
  input  logic [REG_FILE_BITS-1:0] iss_rd,

  input  logic [REG_FILE_BITS-1:0] rs1,
  input  logic [REG_FILE_BITS-1:0] rs2,
  output logic                     haz1,
  output logic                     haz2,
`ifdef WB_ARBITER_FWD_EN
  output logic                     fwd1_valid,
  output logic [REG_SIZE-1:0]      fwd1_data,
  output logic                     fwd2_valid,
  output logic [REG_SIZE-1:0]      fwd2_data,
`endif
  output logic                     wb_we,
  output logic [REG_FILE_BITS-1:0] wb_num,
  output logic [REG_SIZE-1:0]      wb_value
);

  logic [1:0] gnt;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({mem_valid, alu_valid}),
    .gnt_o (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];

  // Write port stage: the winner's rd/data are registered; x0 is accepted but dropped.
  logic                     wb_we_q,    wb_we_d;
  logic [REG_FILE_BITS-1:0] wb_num_q,   wb_num_d;
  logic [REG_SIZE-1:0]      wb_value_q, wb_value_d;

  always_comb begin
    wb_we_d    = 1'b0;
    wb_num_d   = wb_num_q;
    wb_value_d = wb_value_q;
    if (gnt[REQ_ALU]) begin
      wb_we_d    = (alu_rd != '0);
      wb_num_d   = alu_rd;
      wb_value_d = alu_data;
    end else if (gnt[REQ_MEM]) begin
      wb_we_d    = (mem_rd != '0);
      wb_num_d   = mem_rd;
      wb_value_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q    <= 1'b0;
      wb_num_q   <= '0;
      wb_value_q <= '0;
    end else begin
      wb_we_q    <= wb_we_d;
      wb_num_q   <= wb_num_d;
      wb_value_q <= wb_value_d;
    end
  end

  assign wb_we    = wb_we_q;
  assign wb_num   = wb_num_q;
  assign wb_value = wb_value_q;

  // Scoreboard: clear on retiring write first, then set from issue so set wins.
  logic [REG_FILE_SIZE-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wb_we_q) begin
      busy_d[wb_num_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // NOTE: the busy array is a handful of flops, not a RAM, so it is reset
  // like any other state; a reset must leave no stale pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  logic busy1, busy2;
  assign busy1 = (rs1 != '0) && busy_q[rs1];
  assign busy2 = (rs2 != '0) && busy_q[rs2];

`ifdef WB_ARBITER_FWD_EN
  assign fwd1_valid = wb_we_q && (wb_num_q == rs1) && (rs1 != '0);
  assign fwd2_valid = wb_we_q && (wb_num_q == rs2) && (rs2 != '0);
  assign fwd1_data  = wb_value_q;
  assign fwd2_data  = wb_value_q;
  assign haz1       = busy1 && !fwd1_valid;
  assign haz2       = busy2 && !fwd2_valid;
`else
  assign haz1 = busy1;
  assign haz2 = busy2;
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; inputs change on negedge, outputs are sampled
// 1ns later (combinational) or at the following negedge (registered).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int RB = REG_FILE_BITS_DEF;
  localparam int RS = REG_SIZE_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, iss_valid = 1'b0;
  logic [RB-1:0] alu_rd = '0, mem_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [RS-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, haz1, haz2, wb_we;
  logic [RB-1:0] wb_num;
  logic [RS-1:0] wb_value;
`ifdef WB_ARBITER_FWD_EN
  logic          fwd1_valid, fwd2_valid;
  logic [RS-1:0] fwd1_data, fwd2_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .haz1      (haz1),
    .haz2      (haz2),
`ifdef WB_ARBITER_FWD_EN
    .fwd1_valid(fwd1_valid),
    .fwd1_data (fwd1_data),
    .fwd2_valid(fwd2_valid),
    .fwd2_data (fwd2_data),
`endif
    .wb_we     (wb_we),
    .wb_num    (wb_num),
    .wb_value  (wb_value)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    n_checks++; if (wb_num !== '0) begin n_fail++; $display("FAIL reset_wb_num: got %0d want 0", wb_num); end
    n_checks++; if (wb_value !== '0) begin n_fail++; $display("FAIL reset_wb_value: got %h want 0", wb_value); end
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (haz1 !== 1'b0) begin n_fail++; $display("FAIL reset_haz1: got %b want 0", haz1); end
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL single_mem_ready: got %b want 0", mem_ready); end
    @(negedge clk);
    alu_valid = 1'b0;
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL single_wb_we: got %b want 1", wb_we); end
    n_checks++; if (wb_num !== 5'd5) begin n_fail++; $display("FAIL single_wb_num: got %0d want 5", wb_num); end
    n_checks++; if (wb_value !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wb_value: got %h want deadbeef", wb_value); end
    @(negedge clk);
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL single_idle_wb_we: got %b want 0", wb_we); end
  endtask

  task automatic test_round_robin();
    logic [RB-1:0] exp_num;
    logic [RS-1:0] exp_val;
    apply_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 1; alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_rd = 2; mem_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (alu_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_alu_ready[%0d]: got %b want %b", i, alu_ready, (i % 2 == 0)); end
      n_checks++; if (mem_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL rr_mem_ready[%0d]: got %b want %b", i, mem_ready, (i % 2 == 1)); end
      @(negedge clk);
      if (i == 3) begin alu_valid = 1'b0; mem_valid = 1'b0; end
      exp_num = (i % 2 == 0) ? 5'd1 : 5'd2;
      exp_val = (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL rr_wb_we[%0d]: got %b want 1", i, wb_we); end
      n_checks++; if (wb_num !== exp_num) begin n_fail++; $display("FAIL rr_wb_num[%0d]: got %0d want %0d", i, wb_num, exp_num); end
      n_checks++; if (wb_value !== exp_val) begin n_fail++; $display("FAIL rr_wb_value[%0d]: got %h want %h", i, wb_value, exp_val); end
    end
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 0; mem_data = 32'h0000_1234;
    #1;
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_mem_ready: got %b want 1", mem_ready); end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_alu_ready: got %b want 0", alu_ready); end
    @(negedge clk);
    mem_valid = 1'b0;
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rd0_wb_we: got %b want 0", wb_we); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 7; rs1 = 7; rs2 = 0;
    #1;
    n_checks++; if (haz1 !== 1'b0) begin n_fail++; $display("FAIL sb_haz1_before_set: got %b want 0", haz1); end
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    n_checks++; if (haz1 !== 1'b1) begin n_fail++; $display("FAIL sb_haz1_set: got %b want 1", haz1); end
    n_checks++; if (haz2 !== 1'b0) begin n_fail++; $display("FAIL sb_haz2_x0: got %b want 0", haz2); end
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h0000_0777;
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd7) begin n_fail++; $display("FAIL sb_wb7: got we=%b num=%0d want we=1 num=7", wb_we, wb_num); end
    n_checks++; if (haz1 !== 1'b1) begin n_fail++; $display("FAIL sb_haz1_during_wb: got %b want 1", haz1); end
    @(negedge clk);
    #1;
    n_checks++; if (haz1 !== 1'b0) begin n_fail++; $display("FAIL sb_haz1_cleared: got %b want 0", haz1); end
    iss_valid = 1'b1; iss_rd = 7;
    alu_valid = 1'b1; alu_rd = 7;
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd7) begin n_fail++; $display("FAIL sb_wb7_collide: got we=%b num=%0d want we=1 num=7", wb_we, wb_num); end
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    n_checks++; if (haz1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", haz1); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h0000_0333;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_alu_ready: got %b want 1", alu_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_reset: got %b want 0", alu_ready); end
    n_checks++; if (haz1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_cleared: got %b want 0", haz1); end
    alu_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_wb_dropped: got %b want 0", wb_we); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write_after: got %b want 0", wb_we); end
    alu_valid = 1'b1; mem_valid = 1'b1; mem_rd = 4;
    #1;
    n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_prio_alu: got alu=%b mem=%b want alu=1 mem=0", alu_ready, mem_ready); end
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd3) begin n_fail++; $display("FAIL rstmid_regrant: got we=%b num=%0d want we=1 num=3", wb_we, wb_num); end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 9; rs1 = 0; rs2 = 0;
    @(negedge clk);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h0000_0055;
    @(negedge clk);
    alu_valid = 1'b0; rs2 = 9;
    #1;
    n_checks++; if (wb_we !== 1'b1 || wb_num !== 5'd9 || wb_value !== 32'h55) begin n_fail++; $display("FAIL fwd_wb9: got we=%b num=%0d val=%h want 1/9/55", wb_we, wb_num, wb_value); end
`ifdef WB_ARBITER_FWD_EN
    n_checks++; if (fwd2_valid !== 1'b1) begin n_fail++; $display("FAIL fwd2_valid: got %b want 1", fwd2_valid); end
    n_checks++; if (fwd2_data !== 32'h55) begin n_fail++; $display("FAIL fwd2_data: got %h want 55", fwd2_data); end
    n_checks++; if (fwd1_valid !== 1'b0) begin n_fail++; $display("FAIL fwd1_valid_x0: got %b want 0", fwd1_valid); end
    n_checks++; if (haz2 !== 1'b0) begin n_fail++; $display("FAIL fwd_haz2_masked: got %b want 0", haz2); end
`else
    n_checks++; if (haz2 !== 1'b1) begin n_fail++; $display("FAIL nofwd_haz2: got %b want 1", haz2); end
`endif
    @(negedge clk);
    #1;
    n_checks++; if (haz2 !== 1'b0) begin n_fail++; $display("FAIL fwd_haz2_cleared: got %b want 0", haz2); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_rd_zero();
    test_scoreboard();
    test_reset_mid();
    test_forwarding();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_arbiter
